// File: rtl/jet_missile_pool.sv
// Player missile pool: spawns missiles from the jet nose while the fire key
// is held, flies them upward once per frame, and retires them at the top
// edge or when the collision stage reports a hit. All outputs are registered.
module jet_missile_pool #(
  parameter int          NUM_SLOTS = 4,
  parameter int          MISSILE_H = 8,
  parameter int          Y_STEP    = 6,
  parameter int          Y_MIN     = 6,
  parameter int          COOLDOWN  = 8,
  parameter logic [7:0]  FIRE_KEY  = 8'h2C
) (
  input  logic                      frame_clk,
  input  logic                      Reset_n,
  input  logic [7:0]                keycode,
  input  logic [7:0]                keycode1,
  input  logic [7:0]                keycode2,
  input  logic [5:0]                level,
  input  logic [9:0]                JetX,
  input  logic [9:0]                JetY,
  input  logic [9:0]                Jet_H,
  input  logic [NUM_SLOTS-1:0]      hit,
  output logic [10*NUM_SLOTS-1:0]   MissileX,
  output logic [10*NUM_SLOTS-1:0]   MissileY,
  output logic [NUM_SLOTS-1:0]      MissileActive,
  output logic [7:0]                fire_count
);

  localparam logic [9:0]  MH        = 10'(MISSILE_H);
  localparam logic [9:0]  YS        = 10'(Y_STEP);
  localparam logic [9:0]  RETIRE_Y  = 10'(Y_MIN + Y_STEP);
  localparam logic [10:0] FLOOR_ADD = 11'(MISSILE_H + Y_MIN);
  localparam logic [7:0]  CD_RELOAD = 8'(COOLDOWN - 1);
  localparam logic [5:0]  LVL_START = 6'b000001;

  // Packed per-slot state; slot i lives at bits [10i+9:10i] when flattened.
  logic [NUM_SLOTS-1:0][9:0] x_q, x_d;
  logic [NUM_SLOTS-1:0][9:0] y_q, y_d;
  logic [NUM_SLOTS-1:0]      act_q, act_d;
  logic [7:0]                cd_q, cd_d;
  logic [7:0]                fc_q, fc_d;

  logic                      fire_req;
  logic                      start_clr;
  logic [NUM_SLOTS-1:0]      free;
  logic [NUM_SLOTS-1:0]      sel;
  logic                      found;
  logic                      floor_ok;
  logic                      spawn;
  logic [9:0]                spawn_y;

  assign fire_req  = (keycode == FIRE_KEY) | (keycode1 == FIRE_KEY) | (keycode2 == FIRE_KEY);
  assign start_clr = (level == LVL_START);
  // Only slots idle at the start of the frame are candidates, so a slot
  // retiring this frame cannot be reused until the next one.
  assign free      = ~act_q;
  // A nose position too close to the top would put the missile above the
  // legal ceiling (or wrap the subtraction), so such spawns are suppressed.
  assign floor_ok  = ({1'b0, JetY} >= ({1'b0, Jet_H} + FLOOR_ADD));
  assign spawn_y   = JetY - Jet_H - MH;
  assign spawn     = fire_req & (cd_q == 8'd0) & (|free) & floor_ok;

  // Pick the lowest-index free slot as the spawn target (one-hot).
  always_comb begin
    sel   = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (free[i] && !found) begin
        sel[i] = 1'b1;
        found  = 1'b1;
      end else begin
        sel[i] = 1'b0;
      end
    end
  end

  // Next-state: start-screen clear, per-slot retire/fly/spawn, cooldown and counter.
  always_comb begin
    x_d   = x_q;
    y_d   = y_q;
    act_d = act_q;
    cd_d  = cd_q;
    fc_d  = fc_q;
    if (start_clr) begin
      x_d   = '0;
      y_d   = '0;
      act_d = '0;
      cd_d  = 8'd0;
      fc_d  = 8'd0;
    end else begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        if (act_q[i]) begin
          if (hit[i]) begin
            act_d[i] = 1'b0;
          end else if (y_q[i] < RETIRE_Y) begin
            act_d[i] = 1'b0;
          end else begin
            y_d[i] = y_q[i] - YS;
          end
        end else if (spawn && sel[i]) begin
          act_d[i] = 1'b1;
          x_d[i]   = JetX;
          y_d[i]   = spawn_y;
        end else begin
          act_d[i] = 1'b0;
        end
      end
      if (spawn) begin
        cd_d = CD_RELOAD;
        fc_d = fc_q + 8'd1;
      end else if (cd_q != 8'd0) begin
        cd_d = cd_q - 8'd1;
      end else begin
        cd_d = cd_q;
      end
    end
  end

  // State registers with asynchronous clear on Reset_n.
  always_ff @(posedge frame_clk or negedge Reset_n) begin
    if (!Reset_n) begin
      x_q   <= '0;
      y_q   <= '0;
      act_q <= '0;
      cd_q  <= 8'd0;
      fc_q  <= 8'd0;
    end else begin
      x_q   <= x_d;
      y_q   <= y_d;
      act_q <= act_d;
      cd_q  <= cd_d;
      fc_q  <= fc_d;
    end
  end

  assign MissileX      = x_q;
  assign MissileY      = y_q;
  assign MissileActive = act_q;
  assign fire_count    = fc_q;

endmodule
